serial_stuffer: RTL and testbench

SERIAL_STUFFER -- requirements
Module: serial_stuffer

---
 rtl/serial_stuffer.sv | 122 ++++++++++++
 tb/tb_serial_stuffer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_stuffer.sv
// Bit-stuffing serializer: sends DATA_W-bit words LSB first and inserts a 0
// after every RUN_LEN consecutive 1s, carrying the run across back-to-back words.
module serial_stuffer #(
   parameter int DATA_W  = 8,
   parameter int RUN_LEN = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic              ostream,
   output logic              ostream_valid,
   output logic              ostream_stuff
);

   localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [IW-1:0] LAST = IW'(DATA_W - 1);
   localparam logic [2:0]    RMAX = 3'(RUN_LEN);

   typedef enum logic [1:0] {IDLE, SHIFT, STUFF} state_t;

   state_t              state, state_n;
   logic [DATA_W-1:0]   data, data_n;
   logic [IW-1:0]       idx, idx_n, idx_inc;
   logic [2:0]          run, run_n;
   logic                bit_n, valid_n, stuff_n;
   logic                word_end;

   function automatic logic [2:0] bump(input logic [2:0] r, input logic b);
      if (!b)
         return 3'd0;
      return (r >= RMAX) ? RMAX : r + 3'd1;
   endfunction

   // idx is the index of the data bit currently (or last) shown on ostream;
   // it is held through STUFF so the word resumes at idx+1.
   always_comb begin
      state_n   = state;
      data_n    = data;
      idx_n     = idx;
      run_n     = run;
      bit_n     = 1'b0;
      valid_n   = 1'b0;
      stuff_n   = 1'b0;
      din_ready = 1'b0;
      word_end  = 1'b0;
      idx_inc   = idx + 1'b1;

      case (state)
         IDLE: begin
            run_n    = 3'd0;
            word_end = 1'b1;
         end
         SHIFT: begin
            if (run == RMAX) begin
               state_n = STUFF;
               valid_n = 1'b1;
               stuff_n = 1'b1;
               run_n   = 3'd0;
            end else if (idx != LAST) begin
               idx_n   = idx_inc;
               bit_n   = data[idx_inc];
               valid_n = 1'b1;
               run_n   = bump(run, data[idx_inc]);
            end else begin
               word_end = 1'b1;
            end
         end
         STUFF: begin
            if (idx != LAST) begin
               state_n = SHIFT;
               idx_n   = idx_inc;
               bit_n   = data[idx_inc];
               valid_n = 1'b1;
               run_n   = bump(run, data[idx_inc]);
            end else begin
               word_end = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase

      // A word boundary either loads the next word with no gap or drops to IDLE.
      if (word_end) begin
         din_ready = 1'b1;
         if (din_valid) begin
            state_n = SHIFT;
            data_n  = din;
            idx_n   = '0;
            bit_n   = din[0];
            valid_n = 1'b1;
            run_n   = bump(run, din[0]);
         end else begin
            state_n = IDLE;
            idx_n   = '0;
            run_n   = 3'd0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         data          <= '0;
         idx           <= '0;
         run           <= '0;
         ostream       <= 1'b0;
         ostream_valid <= 1'b0;
         ostream_stuff <= 1'b0;
      end else begin
         state         <= state_n;
         data          <= data_n;
         idx           <= idx_n;
         run           <= run_n;
         ostream       <= bit_n;
         ostream_valid <= valid_n;
         ostream_stuff <= stuff_n;
      end
   end

endmodule

// File: tb/tb_serial_stuffer.sv
// Scoreboard bench for serial_stuffer: tests queue expected (bit, stuff) pairs,
// a negedge monitor pops and compares every valid output cycle.
module tb_serial_stuffer;

   localparam int DATA_W  = 8;
   localparam int RUN_LEN = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [DATA_W-1:0] din;
   logic              din_valid;
   logic              din_ready;
   logic              ostream;
   logic              ostream_valid;
   logic              ostream_stuff;

   always #5 clk = ~clk;

   serial_stuffer #(
      .DATA_W (DATA_W),
      .RUN_LEN(RUN_LEN)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .din          (din),
      .din_valid    (din_valid),
      .din_ready    (din_ready),
      .ostream      (ostream),
      .ostream_valid(ostream_valid),
      .ostream_stuff(ostream_stuff)
   );

   typedef struct packed {
      logic b;
      logic s;
   } exp_t;

   exp_t        q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          vcount = 0, falls = 0, sready = 0, run = 0, bitno = 0;
   int          v0 = 0, f0 = 0, s0 = 0;
   logic        prev_valid = 1'b0;
   logic [7:0]  wbuf[4];
   logic [7:0]  tbl[10];

   task automatic check(input string name, input int got, input int want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, got, want);
      end
   endtask

   task automatic push_exp(input int n, input logic [31:0] bits, input logic [31:0] stf);
      for (int i = 0; i < n; i++) q.push_back('{b: bits[i], s: stf[i]});
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (ostream_valid) begin
         vcount++;
         n_cmp++;
         if (q.size() == 0) begin
            n_bad++;
            $display("FAIL stream[%0d]: got ostream=%b stuff=%b, expected no output", bitno, ostream, ostream_stuff);
         end else begin
            e = q.pop_front();
            if (ostream !== e.b || ostream_stuff !== e.s) begin
               n_bad++;
               $display("FAIL stream[%0d]: got ostream=%b stuff=%b, expected ostream=%b stuff=%b",
                        bitno, ostream, ostream_stuff, e.b, e.s);
            end
         end
         bitno++;
         run = ostream ? run + 1 : 0;
         n_cmp++;
         if (run > RUN_LEN) begin
            n_bad++;
            $display("FAIL max_run: got run %0d, limit %0d", run, RUN_LEN);
         end
      end else begin
         if (prev_valid) falls++;
         run = 0;
      end
      if (ostream_stuff && din_ready) sready++;
      prev_valid = ostream_valid;
   end

   task automatic mark();
      v0 = vcount;
      f0 = falls;
      s0 = sready;
   endtask

   task automatic send(input int n);
      for (int i = 0; i < n; i++) begin
         int t;
         @(negedge clk);
         din       = wbuf[i];
         din_valid = 1'b1;
         #1;
         t = 0;
         while (!din_ready && t < 100) begin
            @(negedge clk);
            #1;
            t++;
         end
         check("handshake", int'(din_ready), 1);
         @(posedge clk);
      end
      @(negedge clk);
      din_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int expv, input int expf);
      int t;
      t = 0;
      @(negedge clk);
      while ((ostream_valid || q.size() != 0) && t < 300) begin
         @(negedge clk);
         t++;
      end
      #1;
      check({name, "_idle_valid"}, int'(ostream_valid), 0);
      check({name, "_idle_ready"}, int'(din_ready), 1);
      check({name, "_pending"}, q.size(), 0);
      check({name, "_valid_cycles"}, vcount - v0, expv);
      check({name, "_gaps"}, falls - f0, expf);
   endtask

   initial begin
      rst       = 1'b1;
      din_valid = 1'b0;
      din       = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ostream", int'(ostream), 0);
      check("reset_valid", int'(ostream_valid), 0);
      check("reset_stuff", int'(ostream_stuff), 0);
      check("reset_ready", int'(din_ready), 1);
      rst = 1'b0;

      // single 0xFF
      mark();
      push_exp(10, 32'h1EF, 32'h210);
      wbuf[0] = 8'hFF;
      send(1);
      wait_idle("ff", 10, 1);
      check("ff_stuff_ready", sready - s0, 1);

      // single 0x0F
      mark();
      push_exp(9, 32'h00F, 32'h010);
      wbuf[0] = 8'h0F;
      send(1);
      wait_idle("0f", 9, 1);

      // run carried across 0xC0 -> 0x03
      mark();
      push_exp(17, 32'h3C0, 32'h400);
      wbuf[0] = 8'hC0;
      wbuf[1] = 8'h03;
      send(2);
      wait_idle("c0_03", 17, 1);

      // four back-to-back 0xFF
      mark();
      for (int i = 0; i < 4; i++) begin
         push_exp(10, 32'h1EF, 32'h210);
         wbuf[i] = 8'hFF;
      end
      send(4);
      wait_idle("ffx4", 40, 1);
      check("ffx4_stuff_ready", sready - s0, 4);

      // reset during bit 3 of 0xAA, with a word offered on the reset edge
      push_exp(4, 32'hA, 32'h0);
      @(negedge clk);
      din       = 8'hAA;
      din_valid = 1'b1;
      #1;
      check("aa_ready", int'(din_ready), 1);
      @(posedge clk);
      @(negedge clk);
      din_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst       = 1'b1;
      din_valid = 1'b1;
      din       = 8'h55;
      @(posedge clk);
      @(negedge clk);
      #1;
      check("rst_valid", int'(ostream_valid), 0);
      check("rst_stuff", int'(ostream_stuff), 0);
      check("rst_ready", int'(din_ready), 1);
      check("rst_pending", q.size(), 0);
      rst       = 1'b0;
      din_valid = 1'b0;
      mark();
      push_exp(8, 32'h01, 32'h0);
      wbuf[0] = 8'h01;
      send(1);
      wait_idle("post_rst", 8, 1);

      // din churns while din_ready=0; only tbl[9] sits on din at the next handshake
      tbl = '{8'hAA, 8'h55, 8'h00, 8'h33, 8'hCC, 8'hF0, 8'h81, 8'h7E, 8'hE7, 8'h0F};
      mark();
      push_exp(19, 32'h3DEF, 32'h4210);
      @(negedge clk);
      din       = 8'hFF;
      din_valid = 1'b1;
      #1;
      check("churn_ready", int'(din_ready), 1);
      @(posedge clk);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         din = tbl[i];
      end
      @(posedge clk);
      @(negedge clk);
      din_valid = 1'b0;
      wait_idle("churn", 19, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
